// File: rtl/crossroads_phase_scheduler.sv
// Two-head crossing sequencer: main and side tricolor heads plus pedestrian walk lamp.
// Lamps are active-low; all outputs are registered on the tick clock.
module crossroads_phase_scheduler #(
    parameter int unsigned MAIN_MIN  = 52,
    parameter int unsigned MAIN_BLNK = 8,
    parameter int unsigned SIDE_GRN  = 30,
    parameter int unsigned SIDE_BLNK = 8,
    parameter int unsigned YEL_T     = 6,
    parameter int unsigned RY_T      = 6,
    parameter int unsigned ALLRED_T  = 4
) (
    input  logic       time_signal,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       ped_walk,
    output logic [3:0] phase,
    output logic       req_pending
);

    typedef enum logic [3:0] {
        AR_M   = 4'd0,
        M_RY   = 4'd1,
        M_G    = 4'd2,
        M_BLNK = 4'd3,
        M_Y    = 4'd4,
        AR_S   = 4'd5,
        S_RY   = 4'd6,
        S_G    = 4'd7,
        S_BLNK = 4'd8,
        S_Y    = 4'd9
    } state_e;

    typedef struct packed {
        logic mr;
        logic my;
        logic mg;
        logic sr;
        logic sy;
        logic sg;
        logic walk;
    } lamps_t;

    localparam lamps_t LAMPS_RST = '{mr: 1'b0, my: 1'b1, mg: 1'b1,
                                     sr: 1'b0, sy: 1'b1, sg: 1'b1, walk: 1'b1};

    function automatic logic [7:0] dur_m1(input state_e s);
        logic [7:0] d;
        case (s)
            AR_M, AR_S: d = 8'(ALLRED_T - 1);
            M_RY, S_RY: d = 8'(RY_T - 1);
            M_G:        d = 8'(MAIN_MIN - 1);
            M_BLNK:     d = 8'(MAIN_BLNK - 1);
            S_G:        d = 8'(SIDE_GRN - 1);
            S_BLNK:     d = 8'(SIDE_BLNK - 1);
            M_Y, S_Y:   d = 8'(YEL_T - 1);
            default:    d = 8'(ALLRED_T - 1);
        endcase
        return d;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       side_pend_q, side_pend_d;
    logic       ped_pend_q, ped_pend_d;
    logic       ped_svc_q, ped_svc_d;
    logic       req_pending_q, req_pending_d;
    logic       blink_q, blink_d;
    lamps_t     lamps_q, lamps_d;
    logic       entering_sg;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
        end else if (state_q == M_G && !req_pending_q) begin
            timer_d = '0;
        end else begin
            state_d = (state_q == S_Y) ? AR_M : state_e'(state_q + 4'd1);
            timer_d = dur_m1(state_d);
        end

        // Clear-on-entry is applied before the OR so a same-tick request survives.
        entering_sg   = (state_d == S_G) && (state_q != S_G);
        side_pend_d   = (side_pend_q & ~entering_sg) | side_req;
        ped_pend_d    = (ped_pend_q & ~entering_sg) | ped_req;
        req_pending_d = side_pend_d | ped_pend_d;

        if (entering_sg)
            ped_svc_d = ped_pend_q;
        else if (state_d != S_G)
            ped_svc_d = 1'b0;
        else
            ped_svc_d = ped_svc_q;

        // Blink lamp starts dark on the first blink tick, then alternates.
        blink_d = (state_d != state_q) ? 1'b1 : ~blink_q;

        lamps_d = '1;
        case (state_d)
            AR_M, AR_S: begin lamps_d.mr = 1'b0; lamps_d.sr = 1'b0; end
            M_RY:       begin lamps_d.mr = 1'b0; lamps_d.my = 1'b0; lamps_d.sr = 1'b0; end
            M_G:        begin lamps_d.mg = 1'b0; lamps_d.sr = 1'b0; end
            M_BLNK:     begin lamps_d.mg = blink_d; lamps_d.sr = 1'b0; end
            M_Y:        begin lamps_d.my = 1'b0; lamps_d.sr = 1'b0; end
            S_RY:       begin lamps_d.sr = 1'b0; lamps_d.sy = 1'b0; lamps_d.mr = 1'b0; end
            S_G:        begin lamps_d.sg = 1'b0; lamps_d.mr = 1'b0; end
            S_BLNK:     begin lamps_d.sg = blink_d; lamps_d.mr = 1'b0; end
            S_Y:        begin lamps_d.sy = 1'b0; lamps_d.mr = 1'b0; end
            default:    begin lamps_d.mr = 1'b0; lamps_d.sr = 1'b0; end
        endcase
        lamps_d.walk = ~((state_d == S_G) && ped_svc_d);
    end

    always_ff @(posedge time_signal or posedge reset) begin
        if (reset) begin
            state_q       <= AR_M;
            timer_q       <= 8'(ALLRED_T - 1);
            side_pend_q   <= 1'b0;
            ped_pend_q    <= 1'b0;
            ped_svc_q     <= 1'b0;
            req_pending_q <= 1'b0;
            blink_q       <= 1'b1;
            lamps_q       <= LAMPS_RST;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            side_pend_q   <= side_pend_d;
            ped_pend_q    <= ped_pend_d;
            ped_svc_q     <= ped_svc_d;
            req_pending_q <= req_pending_d;
            blink_q       <= blink_d;
            lamps_q       <= lamps_d;
        end
    end

    assign main_red    = lamps_q.mr;
    assign main_yellow = lamps_q.my;
    assign main_green  = lamps_q.mg;
    assign side_red    = lamps_q.sr;
    assign side_yellow = lamps_q.sy;
    assign side_green  = lamps_q.sg;
    assign ped_walk    = lamps_q.walk;
    assign phase       = state_q;
    assign req_pending = req_pending_q;

endmodule

// File: tb/tb_crossroads_phase_scheduler.sv
// Randomized bench for crossroads_phase_scheduler against a phase/elapsed-tick reference model.
module tb_crossroads_phase_scheduler;

    logic       time_signal = 1'b0;
    logic       reset = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic       ped_walk;
    logic [3:0] phase;
    logic       req_pending;

    crossroads_phase_scheduler #(
        .MAIN_MIN (52),
        .MAIN_BLNK(8),
        .SIDE_GRN (30),
        .SIDE_BLNK(8),
        .YEL_T    (6),
        .RY_T     (6),
        .ALLRED_T (4)
    ) dut (
        .time_signal(time_signal),
        .reset      (reset),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_red   (main_red),
        .main_yellow(main_yellow),
        .main_green (main_green),
        .side_red   (side_red),
        .side_yellow(side_yellow),
        .side_green (side_green),
        .ped_walk   (ped_walk),
        .phase      (phase),
        .req_pending(req_pending)
    );

    always #5 time_signal = ~time_signal;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index, ticks elapsed in phase, latched requests.
    int unsigned dur [10] = '{4, 6, 52, 8, 6, 4, 6, 30, 8, 6};
    int unsigned m_p, m_e;
    bit m_ps, m_pp, m_svc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_p = 0; m_e = 0; m_ps = 0; m_pp = 0; m_svc = 0;
    endfunction

    function automatic void model_step(input bit s, input bit p);
        bit leave;
        leave = (m_e + 1 >= dur[m_p]) && !(m_p == 2 && !(m_ps || m_pp));
        if (leave) begin
            m_p = (m_p + 1) % 10;
            m_e = 0;
            if (m_p == 7) begin
                m_svc = m_pp;
                m_ps = 0;
                m_pp = 0;
            end
        end else if (m_e < 1000) begin
            m_e++;
        end
        if (m_p != 7) m_svc = 0;
        m_ps |= s;
        m_pp |= p;
    endfunction

    // {main r,y,g, side r,y,g, walk}, active-low
    function automatic logic [6:0] exp_lamps();
        logic mr, my, mg, sr, sy, sg, w;
        mr = (m_p inside {0, 1, 5, 6, 7, 8, 9}) ? 1'b0 : 1'b1;
        my = (m_p == 1 || m_p == 4) ? 1'b0 : 1'b1;
        mg = (m_p == 2) ? 1'b0 : (m_p == 3) ? ((m_e % 2) == 0) : 1'b1;
        sr = (m_p <= 6) ? 1'b0 : 1'b1;
        sy = (m_p == 6 || m_p == 9) ? 1'b0 : 1'b1;
        sg = (m_p == 7) ? 1'b0 : (m_p == 8) ? ((m_e % 2) == 0) : 1'b1;
        w  = (m_p == 7 && m_svc) ? 1'b0 : 1'b1;
        return {mr, my, mg, sr, sy, sg, w};
    endfunction

    task automatic compare_all();
        check("phase", 32'(phase), 32'(m_p));
        check("req_pending", 32'(req_pending), 32'(m_ps | m_pp));
        check("lamps", 32'({main_red, main_yellow, main_green, side_red, side_yellow,
                            side_green, ped_walk}), 32'(exp_lamps()));
        check("no_dual_green", 32'(main_green | side_green), 32'd1);
        check("phase_range", 32'(phase <= 4'd9), 32'd1);
    endtask

    task automatic tick(input bit s, input bit p);
        side_req = s;
        ped_req  = p;
        @(posedge time_signal);
        model_step(s, p);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #2 compare_all();
        @(posedge time_signal);
        #1 compare_all();
        @(negedge time_signal);
        reset = 1'b0;

        // Idle: main green holds indefinitely.
        repeat (270) tick(1'b0, 1'b0);

        // Sparse random requests.
        repeat (900) tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);

        // Side request held: full cycles at minimum main green.
        repeat (300) tick(1'b1, 1'b0);

        // Pedestrian pulses at random points, with side traffic held.
        repeat (400) tick(1'b1, $urandom_range(0, 29) == 0);

        // Drive to side blink, then reset asynchronously mid-phase.
        for (int i = 0; i < 300; i++) begin
            if (m_p == 8) break;
            tick(1'b1, 1'b0);
        end
        check("reach_s_blnk", 32'(phase), 32'd8);
        side_req = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        @(posedge time_signal);
        #1 compare_all();
        @(negedge time_signal);
        reset = 1'b0;

        repeat (80) tick(1'b0, 1'b0);
        repeat (600) tick($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
